// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory arbiter.
//   ADDR_W        : data-memory byte address width (12)
//   WE_* / RD_*   : store / load encodings on the request and memory ports
//   state_t       : arbiter FSM states
//   req_t         : one captured memory request (address, store, load, data)
//   mem_we()      : maps a request store code onto the memory port code
//   is_load()     : true for any load encoding
package dm_pkg;

  localparam int ADDR_W = 12;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_SW   = 2'b01;
  localparam logic [1:0] WE_SB   = 2'b10;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_LW   = 2'b01;
  localparam logic [1:0] RD_LB   = 2'b10;
  localparam logic [1:0] RD_LBU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        we;
    logic [1:0]        rd;
    logic [31:0]       wdata;
  } req_t;

  // The reserved store code 11 never reaches the memory as a write.
  function automatic logic [1:0] mem_we(input logic [1:0] we);
    case (we)
      WE_SW:   return WE_SW;
      WE_SB:   return WE_SB;
      default: return WE_NONE;
    endcase
  endfunction

  function automatic logic is_load(input logic [1:0] rd);
    return (rd == RD_LW) || (rd == RD_LB) || (rd == RD_LBU);
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: chooses which requester is served next.
//   req0, req1 : live request lines of m0 / m1
//   prefer1    : (only with DM_ARB_RR_EN) m1 wins a tie when high
//   valid      : some requester is pending
//   sel        : 0 = m0 chosen, 1 = m1 chosen
// Build option: DM_ARB_RR_EN defined selects round-robin on ties; otherwise
// m0 always has priority over m1.
module dm_arb_pick (
  input  logic req0,
  input  logic req1,
`ifdef DM_ARB_RR_EN
  input  logic prefer1,
`endif
  output logic valid,
  output logic sel
);

  always_comb begin
    valid = req0 | req1;
`ifdef DM_ARB_RR_EN
    sel = req1 & (~req0 | prefer1);
`else
    sel = req1 & ~req0;
`endif
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between the CPU MEM stage (m0)
// and a loader/debug requester (m1).
//   clk, rst_n          : clock, asynchronous active-low reset
//   mX_req/addr/we/rd/wdata : request, held until mX_gnt
//   mX_gnt              : access performed this cycle
//   mX_rdata, mX_rvalid : registered load data and its one-cycle valid
//   dm_addr/din/we/memRead, dm_dout : memory port (memory writes on negedge,
//                         reads combinationally)
//   cpu_stall           : m0_req & ~m0_gnt
//   err                 : pulses while serving a request with both store
//                         and load set
// Build option: DM_ARB_RR_EN selects round-robin arbitration (default is
// fixed priority, m0 first).
module dm_arbiter
  import dm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [1:0]        m0_we,
  input  logic [1:0]        m0_rd,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic [31:0]       m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m1_we,
  input  logic [1:0]        m1_rd,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic [31:0]       m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic [1:0]        dm_we,
  output logic [1:0]        dm_memRead,
  input  logic [31:0]       dm_dout,
  output logic              cpu_stall,
  output logic              err
);

  state_t      state_reg, state_next;
  req_t        fld_reg;
  req_t        m0_fld, m1_fld;
  logic        pick_valid, pick_sel;
  logic        illegal, load0, load1;
  logic [31:0] m0_rdata_reg, m1_rdata_reg;
  logic        m0_rvalid_reg, m1_rvalid_reg;

  assign m0_fld = '{addr: m0_addr, we: m0_we, rd: m0_rd, wdata: m0_wdata};
  assign m1_fld = '{addr: m1_addr, we: m1_we, rd: m1_rd, wdata: m1_wdata};

`ifdef DM_ARB_RR_EN
  // High when m1 should win the next tie, i.e. m0 was served last.
  logic prefer1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prefer1_reg <= 1'b0;
    else if (pick_valid)
      prefer1_reg <= ~pick_sel;
  end

  dm_arb_pick u_pick (
    .req0    (m0_req),
    .req1    (m1_req),
    .prefer1 (prefer1_reg),
    .valid   (pick_valid),
    .sel     (pick_sel)
  );
`else
  dm_arb_pick u_pick (
    .req0  (m0_req),
    .req1  (m1_req),
    .valid (pick_valid),
    .sel   (pick_sel)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next state: arbitration happens every cycle, including during a grant,
  // so back-to-back service needs no IDLE cycle in between.
  always_comb begin
    state_next = IDLE;
    if (pick_valid)
      state_next = pick_sel ? SERVE1 : SERVE0;
  end

  assign illegal = (fld_reg.we != WE_NONE) && (fld_reg.rd != RD_NONE);
  assign load0   = (state_reg == SERVE0) && !illegal && is_load(fld_reg.rd);
  assign load1   = (state_reg == SERVE1) && !illegal && is_load(fld_reg.rd);

  // Outputs.
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    err        = 1'b0;
    dm_addr    = '0;
    dm_din     = '0;
    dm_we      = WE_NONE;
    dm_memRead = RD_NONE;
    if (state_reg == SERVE0 || state_reg == SERVE1) begin
      m0_gnt  = (state_reg == SERVE0);
      m1_gnt  = (state_reg == SERVE1);
      dm_addr = fld_reg.addr;
      dm_din  = fld_reg.wdata;
      if (illegal) begin
        err = 1'b1;
      end else begin
        dm_we      = mem_we(fld_reg.we);
        dm_memRead = fld_reg.rd;
      end
    end
    cpu_stall = m0_req & ~m0_gnt;
  end

  // Request capture on the edge entering SERVEx, load data on the edge
  // leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fld_reg       <= '0;
      m0_rdata_reg  <= '0;
      m1_rdata_reg  <= '0;
      m0_rvalid_reg <= 1'b0;
      m1_rvalid_reg <= 1'b0;
    end else begin
      if (pick_valid)
        fld_reg <= pick_sel ? m1_fld : m0_fld;
      m0_rvalid_reg <= load0;
      m1_rvalid_reg <= load1;
      if (load0)
        m0_rdata_reg <= dm_dout;
      if (load1)
        m1_rdata_reg <= dm_dout;
    end
  end

  assign m0_rdata  = m0_rdata_reg;
  assign m1_rdata  = m1_rdata_reg;
  assign m0_rvalid = m0_rvalid_reg;
  assign m1_rvalid = m1_rvalid_reg;

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock), rst_n (input, 1, asynchronous active-low reset).
REQ-002 m0_req  in  1  CPU MEM-stage access request, held high until granted.
REQ-003 m0_addr  in  12  byte address; m0_we  in  2  (00 none, 01 SW, 10 SB); m0_rd  in  2  (00 none, 01 LW, 10 LB, 11 LBU); m0_wdata  in  32.
REQ-004 m0_gnt  out  1  access performed this cycle; m0_rdata  out  32  registered load data; m0_rvalid  out  1  rdata valid pulse.
REQ-005 m1_req, m1_addr, m1_we, m1_rd, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as m0_*, for the loader/debug requester.
REQ-006 dm_addr  out  12; dm_din  out  32; dm_we  out  2; dm_memRead  out  2; dm_dout  in  32  (data memory port; the memory writes on negedge and reads combinationally).
REQ-007 cpu_stall  out  1  = m0_req & ~m0_gnt (combinational); err  out  1  one-cycle illegal-request pulse.

Function
REQ-008 FSM states: IDLE, SERVE0, SERVE1; state updates on the rising clock edge.
REQ-009 IDLE or SERVEx -> SERVE0/SERVE1 when the chosen requester has req=1; -> IDLE when no req is pending.
REQ-010 Request fields SHALL be registered on the edge entering SERVEx; the requester SHALL hold req and fields stable until gnt.
REQ-011 In SERVEx: mx_gnt=1; dm_* are driven from the registered fields; the other gnt=0.
REQ-012 Outside SERVEx: dm_we=00, dm_memRead=00, dm_addr=0, dm_din=0 (no spurious write).
REQ-013 Access latency: gnt is asserted at the earliest one cycle after req rises; back-to-back service SHALL occur without an IDLE bubble.
REQ-014 Loads: dm_dout SHALL be captured into mx_rdata at the edge ending SERVEx, and mx_rvalid=1 for exactly the following cycle; rdata holds until the next load of that requester.
REQ-015 Stores: rvalid SHALL stay 0; rdata SHALL be unchanged.
REQ-016 Illegal request (we!=00 and rd!=00): granted, dm_we=dm_memRead=00 driven, err pulses during that SERVE cycle, rvalid=0.
REQ-017 A request with we=00 and rd=00 SHALL be granted as a no-op, without err.
REQ-018 After gnt, the requester SHALL drop req or present a new request in the next cycle; a held req SHALL be treated as a new request.

Reset
REQ-019 With rst_n low: state=IDLE, all gnt/rvalid/err=0, rdata=0, registered fields=0, RR pointer=0 (m0 preferred), dm_we/dm_memRead=00, regardless of any in-flight access.
REQ-020 On reset release, the first arbitration SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-021 Macro DM_ARB_RR_EN defined: round-robin; when both request, the one not served last wins; the pointer updates on each grant.
REQ-022 DM_ARB_RR_EN undefined: fixed priority, m0 over m1; m1 may starve; no pointer register.

Structure
REQ-023 A shared package dm_pkg SHALL hold the we encodings (WE_NONE/SW/SB), rd encodings (RD_NONE/LW/LB/LBU), the FSM state type and address width 12.
REQ-024 One sub-module, dm_arb_pick (the grant-select logic, RR or fixed), is natural; the FSM and datapath registers stay in the top level.

Verification
REQ-025 m0 SW addr 0x010 data 0xDEADBEEF, then m0 LW 0x010 -> m0_rdata=0xDEADBEEF with rvalid one cycle after the second gnt.
REQ-026 m1 SB 0x013 data 0x80, then m1 LB 0x013 -> 0xFFFFFF80; LBU -> 0x00000080.
REQ-027 m0 and m1 request continuously for 6 cycles: RR -> grants alternate 0,1,0,1,0,1; fixed -> m0 every cycle, cpu_stall=0, m1_gnt=0.
REQ-028 m0 we=01 rd=01 -> err=1 for one cycle, dm_we=00, memory unchanged at the address, no rvalid.
REQ-029 rst_n dropped during SERVE1 of a SW -> outputs zero immediately; after release, an m0-only request is granted first.
REQ-030 m0 request while m1 is served -> cpu_stall=1 until m0_gnt, then 0.
